reg_writer: RTL and testbench

REG_WRITER -- requirements
Module: reg_writer

---
 rtl/reg_writer.sv | 58 +++++
 tb/tb_reg_writer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/reg_writer.sv
// reg_writer: 4-entry in-order write-back FIFO merging load and ALU results into a register-file write port
module reg_writer (
  input  logic        clk,
  input  logic        Reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic [4:0]  Wn,
  output logic [31:0] Wd,
  output logic        a1,
  output logic [31:0] busy,
  output logic [2:0]  count
);
  logic [4:0]  rd_q [4];
  logic [31:0] data_q [4];
  logic [1:0]  wp, rp;
  logic        acc_mem, acc_alu, enq;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  assign mem_ready = !count[2];
  assign alu_ready = mem_ready && !mem_valid;
  assign acc_mem   = mem_valid && mem_ready;
  assign acc_alu   = alu_valid && alu_ready;
  assign in_rd     = acc_mem ? mem_rd : alu_rd;
  assign in_data   = acc_mem ? mem_data : alu_data;
  assign enq       = (acc_mem || acc_alu) && in_rd != 5'd0;
  assign a1        = count != 3'd0;
  assign Wn        = a1 ? rd_q[rp] : 5'd0;
  assign Wd        = a1 ? data_q[rp] : 32'd0;
  always_comb begin
    busy = '0;
    for (int i = 0; i < 4; i++)
      if ({1'b0, 2'(2'(i) - rp)} < count) busy[rd_q[i]] = 1'b1;
    busy[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + 2'(enq);
      rp    <= rp + 2'(a1);
      count <= count + 3'(enq) - 3'(a1);
    end
  end
  always_ff @(posedge clk) begin
    if (enq && !Reset) begin
      rd_q[wp]   <= in_rd;
      data_q[wp] <= in_data;
    end
  end
endmodule

// File: tb/tb_reg_writer.sv
// tb_reg_writer: scoreboard bench for reg_writer
module tb_reg_writer;
  logic        clk = 0;
  logic        Reset = 0;
  logic        alu_valid = 0, mem_valid = 0;
  logic [4:0]  alu_rd = 0, mem_rd = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic        alu_ready, mem_ready, a1;
  logic [4:0]  Wn;
  logic [31:0] Wd, busy;
  logic [2:0]  count;
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t q[$];
  ent_t wlog[$];
  int total = 0, bad = 0;

  reg_writer dut (
    .clk(clk), .Reset(Reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .Wn(Wn), .Wd(Wd), .a1(a1), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    logic [31:0] eb;
    logic        mr, ar;
    #1;
    eb = 0;
    foreach (q[i]) eb[q[i].rd] = 1'b1;
    eb[0] = 1'b0;
    mr = q.size() < 4;
    ar = mr && !mem_valid;
    check("count", 32'(count), 32'(q.size()));
    check("a1", 32'(a1), 32'(q.size() != 0));
    check("wn", 32'(Wn), q.size() ? 32'(q[0].rd) : 32'd0);
    check("wd", Wd, q.size() ? q[0].data : 32'd0);
    check("busy", busy, eb);
    check("mem_ready", 32'(mem_ready), 32'(mr));
    check("alu_ready", 32'(alu_ready), 32'(ar));
    if (a1) wlog.push_back({Wn, Wd});
    @(posedge clk);
    if (Reset) q.delete();
    else begin
      if (q.size()) void'(q.pop_front());
      if (mem_valid && mr) begin
        if (mem_rd != 0) q.push_back({mem_rd, mem_data});
      end else if (alu_valid && ar && alu_rd != 0) q.push_back({alu_rd, alu_data});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    alu_valid = 0; mem_valid = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #1 Reset = 1;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_a1", 32'(a1), 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    cyc();
    Reset = 0;
    cyc();
    // single ALU write: visible one cycle, then gone
    alu_valid = 1; alu_rd = 1; alu_data = 32'hAA;
    cyc();
    alu_valid = 0;
    check("s_a1", 32'(a1), 1);
    check("s_wn", 32'(Wn), 1);
    check("s_wd", Wd, 32'hAA);
    check("s_busy", busy, 32'h2);
    cyc();
    check("s_cnt", 32'(count), 0);
    idle(1);
    // load wins over ALU; ALU held then accepted
    wlog.delete();
    alu_valid = 1; alu_rd = 2; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 3; mem_data = 32'h22;
    cyc();
    mem_valid = 0;
    cyc();
    idle(3);
    check("ord_n", 32'(wlog.size()), 2);
    if (wlog.size() == 2) begin
      check("ord0", {27'd0, wlog[0].rd}, 3);
      check("ord0d", wlog[0].data, 32'h22);
      check("ord1", {27'd0, wlog[1].rd}, 2);
      check("ord1d", wlog[1].data, 32'h11);
    end
    // rd=0 discarded
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    cyc();
    alu_valid = 0;
    check("z_cnt", 32'(count), 0);
    check("z_a1", 32'(a1), 0);
    idle(1);
    // six back-to-back loads
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1; mem_rd = 5'(10 + i); mem_data = 32'(100 + i);
      cyc();
    end
    idle(3);
    check("six_n", 32'(wlog.size()), 6);
    foreach (wlog[i]) check("six_d", wlog[i].data, 32'(100 + i));
    // same register twice
    wlog.delete();
    alu_valid = 1; alu_rd = 5; alu_data = 1;
    cyc();
    alu_data = 2;
    cyc();
    alu_valid = 0;
    check("b5", 32'(busy[5]), 1);
    idle(3);
    check("b5_clr", 32'(busy[5]), 0);
    if (wlog.size() == 2) check("last", wlog[1].data, 2);
    else check("last_n", 32'(wlog.size()), 2);
    // reset mid-operation, valid held across reset edge
    mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
    cyc();
    #2 Reset = 1;
    #1;
    check("mr_a1", 32'(a1), 0);
    check("mr_cnt", 32'(count), 0);
    check("mr_busy", busy, 0);
    q.delete();
    @(negedge clk);
    cyc();
    mem_valid = 0;
    Reset = 0;
    wlog.delete();
    idle(3);
    check("mr_nowr", 32'(wlog.size()), 0);
    // random traffic
    for (int i = 0; i < 60; i++) begin
      alu_valid = 1'($urandom); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      mem_valid = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      cyc();
    end
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
